// File: rtl/sdram_test_pkg.sv
// Shared definitions for the SDRAM memory-test traffic generator:
// default widths, the GPIO-visible state encoding and the data pattern.
package sdram_test_pkg;

  localparam int unsigned DEF_ADDR_W = 27;
  localparam int unsigned DEF_DATA_W = 32;

  // Encodings are exported on o_state, so the values are fixed.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_REQ  = 3'd1,
    ST_WR_WAIT = 3'd2,
    ST_RD_REQ  = 3'd3,
    ST_RD_WAIT = 3'd4,
    ST_DONE    = 3'd5,
    ST_FAIL    = 3'd6
  } state_e;

  // Word i carries the seed XORed with its index and the index complement,
  // so every word differs from its neighbours in both halves.
  function automatic logic [31:0] pattern_data(input logic [31:0] seed,
                                               input logic [15:0] idx);
    return seed ^ {idx, ~idx};
  endfunction

endpackage

// File: rtl/memtest_pattern_gen.sv
// Combinational index -> (address, data) mapping of the memory-test pattern.
// Kept separate so a read-only check mode can regenerate the same sequence.
module memtest_pattern_gen
  import sdram_test_pkg::*;
#(
  parameter int unsigned       ADDR_W     = DEF_ADDR_W,
  parameter int unsigned       DATA_W     = DEF_DATA_W,
  parameter logic [ADDR_W-1:0] START_ADDR = '0,
  parameter int unsigned       ADDR_STEP  = 2,
  parameter logic [31:0]       SEED       = 32'h5555_AAAA
) (
  input  logic [31:0]       i_idx,
  output logic [ADDR_W-1:0] o_addr,
  output logic [DATA_W-1:0] o_data
);

  logic [31:0] pat;

  // Address wraps modulo 2^ADDR_W; data is the seeded pattern resized to DATA_W.
  always_comb begin
    o_addr = START_ADDR + ADDR_W'(i_idx * ADDR_STEP);
    pat    = pattern_data(SEED, i_idx[15:0]);
    o_data = DATA_W'(pat);
  end

endmodule

// File: rtl/sdram_memtest_seq.sv
// Self-checking SDRAM traffic generator: writes a pattern over an address
// window, reads it back, counts mismatches and flags missing acknowledges.
// One request outstanding at a time.
module sdram_memtest_seq
  import sdram_test_pkg::*;
#(
  parameter int unsigned       ADDR_W     = DEF_ADDR_W,
  parameter int unsigned       DATA_W     = DEF_DATA_W,
  parameter logic [ADDR_W-1:0] START_ADDR = '0,
  parameter int unsigned       NUM_WORDS  = 1024,
  parameter int unsigned       ADDR_STEP  = 2,
  parameter logic [31:0]       SEED       = 32'h5555_AAAA,
  parameter int unsigned       TIMEOUT    = 4096
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_init_done,
  input  logic              i_ctrl_busy,
  input  logic              i_ctrl_ack,
  input  logic [DATA_W-1:0] i_rd_data,
  output logic              o_adv_n,
  output logic              o_rwn,
  output logic [ADDR_W-1:0] o_addr,
  output logic [DATA_W-1:0] o_wr_data,
  output logic              o_done,
  output logic              o_pass,
  output logic              o_timeout,
  output logic [15:0]       o_err_count,
  output logic [ADDR_W-1:0] o_err_addr,
  output logic [DATA_W-1:0] o_err_data,
  output logic [2:0]        o_state
);

  localparam logic [31:0] LAST_IDX = 32'(NUM_WORDS - 1);
  localparam logic [31:0] TMO_LAST = 32'(TIMEOUT - 1);

  state_e              state_q, state_d;
  logic [31:0]         idx_q, idx_d;
  logic [31:0]         tmo_q, tmo_d;
  logic                rwn_q, rwn_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wr_data_q, wr_data_d;
  logic                done_q, done_d;
  logic                pass_q, pass_d;
  logic                timeout_q, timeout_d;
  logic [15:0]         err_cnt_q, err_cnt_d;
  logic [ADDR_W-1:0]   err_addr_q, err_addr_d;
  logic [DATA_W-1:0]   err_data_q, err_data_d;
  logic                adv_n;
  logic                mism;
  logic [ADDR_W-1:0]   gen_addr;
  logic [DATA_W-1:0]   gen_data;

  // Pattern for the index the sequencer moves to, so the request registers
  // already hold the right address/data in the first request cycle.
  memtest_pattern_gen #(
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .START_ADDR (START_ADDR),
    .ADDR_STEP  (ADDR_STEP),
    .SEED       (SEED)
  ) u_pattern (
    .i_idx  (idx_d),
    .o_addr (gen_addr),
    .o_data (gen_data)
  );

  // Sequencer: next state, index, timeout counter, status and error capture.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    tmo_d      = tmo_q;
    done_d     = done_q;
    pass_d     = pass_q;
    timeout_d  = timeout_q;
    err_cnt_d  = err_cnt_q;
    err_addr_d = err_addr_q;
    err_data_d = err_data_q;
    adv_n      = 1'b1;
    // During a read the write-data register holds the expected word.
    mism       = (i_rd_data != wr_data_q);

    unique case (state_q)
      ST_IDLE, ST_DONE, ST_FAIL: begin
        if (i_start && i_init_done) begin
          state_d    = ST_WR_REQ;
          idx_d      = '0;
          tmo_d      = '0;
          done_d     = 1'b0;
          pass_d     = 1'b0;
          timeout_d  = 1'b0;
          err_cnt_d  = '0;
          err_addr_d = '0;
          err_data_d = '0;
        end
      end
      ST_WR_REQ, ST_RD_REQ: begin
        if (!i_ctrl_busy) begin
          adv_n   = 1'b0;
          tmo_d   = '0;
          state_d = (state_q == ST_WR_REQ) ? ST_WR_WAIT : ST_RD_WAIT;
        end
      end
      ST_WR_WAIT: begin
        if (i_ctrl_ack) begin
          if (idx_q == LAST_IDX) begin
            state_d = ST_RD_REQ;
            idx_d   = '0;
          end else begin
            state_d = ST_WR_REQ;
            idx_d   = idx_q + 32'd1;
          end
        end else if (tmo_q == TMO_LAST) begin
          state_d   = ST_FAIL;
          timeout_d = 1'b1;
          done_d    = 1'b1;
        end else begin
          tmo_d = tmo_q + 32'd1;
        end
      end
      ST_RD_WAIT: begin
        if (i_ctrl_ack) begin
          if (mism) begin
            if (err_cnt_q == '0) begin
              err_addr_d = addr_q;
              err_data_d = i_rd_data;
            end
            if (err_cnt_q != 16'hFFFF) begin
              err_cnt_d = err_cnt_q + 16'd1;
            end
          end
          if (idx_q == LAST_IDX) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            pass_d  = (err_cnt_q == '0) && !mism;
          end else begin
            state_d = ST_RD_REQ;
            idx_d   = idx_q + 32'd1;
          end
        end else if (tmo_q == TMO_LAST) begin
          state_d   = ST_FAIL;
          timeout_d = 1'b1;
          done_d    = 1'b1;
        end else begin
          tmo_d = tmo_q + 32'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Request registers reload whenever the sequencer is (or stays) in a
  // request state and hold otherwise, keeping them stable until the ack.
  always_comb begin
    addr_d    = addr_q;
    wr_data_d = wr_data_q;
    rwn_d     = rwn_q;
    if (state_d == ST_WR_REQ || state_d == ST_RD_REQ) begin
      addr_d    = gen_addr;
      wr_data_d = gen_data;
      rwn_d     = (state_d == ST_RD_REQ);
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      tmo_q      <= '0;
      rwn_q      <= 1'b1;
      addr_q     <= '0;
      wr_data_q  <= '0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      timeout_q  <= 1'b0;
      err_cnt_q  <= '0;
      err_addr_q <= '0;
      err_data_q <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      tmo_q      <= tmo_d;
      rwn_q      <= rwn_d;
      addr_q     <= addr_d;
      wr_data_q  <= wr_data_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      timeout_q  <= timeout_d;
      err_cnt_q  <= err_cnt_d;
      err_addr_q <= err_addr_d;
      err_data_q <= err_data_d;
    end
  end

  assign o_adv_n     = adv_n;
  assign o_rwn       = rwn_q;
  assign o_addr      = addr_q;
  assign o_wr_data   = wr_data_q;
  assign o_done      = done_q;
  assign o_pass      = pass_q;
  assign o_timeout   = timeout_q;
  assign o_err_count = err_cnt_q;
  assign o_err_addr  = err_addr_q;
  assign o_err_data  = err_data_q;
  assign o_state     = state_q;

endmodule

// File: tb/tb_sdram_memtest_seq.sv
// Directed bench for sdram_memtest_seq with a small controller model
// (busy driven by the stimulus, ack three cycles after each strobe).
module tb_sdram_memtest_seq;

  localparam int ADDR_W = 27;
  localparam int DATA_W = 32;

  logic              clk;
  logic              rst;
  logic              start;
  logic              init_done;
  logic              busy;
  logic              ack_m;
  logic              ack_spur;
  logic              ctrl_ack;
  logic [DATA_W-1:0] rd_data;
  logic              adv_n;
  logic              rwn;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wr_data;
  logic              done;
  logic              pass;
  logic              tmo;
  logic [15:0]       err_count;
  logic [ADDR_W-1:0] err_addr;
  logic [DATA_W-1:0] err_data;
  logic [2:0]        state;

  assign ctrl_ack = ack_m | ack_spur;

  sdram_memtest_seq #(
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .START_ADDR ('0),
    .NUM_WORDS  (4),
    .ADDR_STEP  (2),
    .SEED       (32'h5555_AAAA),
    .TIMEOUT    (16)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_start     (start),
    .i_init_done (init_done),
    .i_ctrl_busy (busy),
    .i_ctrl_ack  (ctrl_ack),
    .i_rd_data   (rd_data),
    .o_adv_n     (adv_n),
    .o_rwn       (rwn),
    .o_addr      (addr),
    .o_wr_data   (wr_data),
    .o_done      (done),
    .o_pass      (pass),
    .o_timeout   (tmo),
    .o_err_count (err_count),
    .o_err_addr  (err_addr),
    .o_err_data  (err_data),
    .o_state     (state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hand-computed pattern: 5555AAAA ^ {i, ~i}
  logic [31:0] exp_data [0:3];
  logic [26:0] exp_addr [0:3];

  int          n_checks;
  int          n_fail;

  // Controller model state and request log
  logic        model_en;
  logic [31:0] mem     [0:7];
  logic [31:0] corrupt [0:7];
  int          pend_cnt;
  logic [2:0]  pend_a;
  logic        pend_rwn;
  int          n_req;
  logic [26:0] log_addr [0:127];
  logic        log_rwn  [0:127];
  logic [31:0] log_data [0:127];

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_state(input logic [2:0] st, input int lim, input string tag);
    int n;
    n = 0;
    while (state != st && n < lim) begin
      tick();
      n++;
    end
    check_val(tag, 64'(state), 64'(st));
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check_val({tag, "_state"},  64'(state),     64'd0);
    check_val({tag, "_adv_n"},  64'(adv_n),     64'd1);
    check_val({tag, "_rwn"},    64'(rwn),       64'd1);
    check_val({tag, "_addr"},   64'(addr),      64'd0);
    check_val({tag, "_wdata"},  64'(wr_data),   64'd0);
    check_val({tag, "_done"},   64'(done),      64'd0);
    check_val({tag, "_pass"},   64'(pass),      64'd0);
    check_val({tag, "_tmo"},    64'(tmo),       64'd0);
    check_val({tag, "_errcnt"}, 64'(err_count), 64'd0);
    check_val({tag, "_erradr"}, 64'(err_addr),  64'd0);
    check_val({tag, "_errdat"}, 64'(err_data),  64'd0);
  endtask

  // Checks that the last eight strobes were four writes then four reads
  // of the expected pattern.
  task automatic check_log(input int base, input string tag);
    for (int k = 0; k < 8; k++) begin
      check_val($sformatf("%s_req%0d_addr", tag, k), 64'(log_addr[(base + k) % 128]), 64'(exp_addr[k % 4]));
      check_val($sformatf("%s_req%0d_rwn", tag, k),  64'(log_rwn[(base + k) % 128]),  64'(k >= 4));
      if (k < 4)
        check_val($sformatf("%s_req%0d_data", tag, k), 64'(log_data[(base + k) % 128]), 64'(exp_data[k]));
    end
  endtask

  // Controller model: observes strobes mid-cycle, acks three cycles later.
  initial begin
    ack_m    = 1'b0;
    rd_data  = '0;
    pend_cnt = 0;
    pend_a   = '0;
    pend_rwn = 1'b0;
    n_req    = 0;
    for (int i = 0; i < 8; i++) begin
      mem[i] = '0;
    end
    forever begin
      @(negedge clk);
      ack_m = 1'b0;
      if (pend_cnt > 0) begin
        pend_cnt--;
        if (pend_cnt == 0) begin
          ack_m = 1'b1;
          if (pend_rwn) rd_data = mem[pend_a] ^ corrupt[pend_a];
        end
      end
      if (!adv_n && !rst) begin
        log_addr[n_req % 128] = addr;
        log_rwn[n_req % 128]  = rwn;
        log_data[n_req % 128] = wr_data;
        n_req++;
        if (!rwn) mem[addr[3:1]] = wr_data;
        if (model_en) begin
          pend_cnt = 3;
          pend_a   = addr[3:1];
          pend_rwn = rwn;
        end
      end
    end
  end

  initial begin
    int base;
    int bad_strobe;
    int bad_hold;

    exp_data[0] = 32'h5555_5555;
    exp_data[1] = 32'h5554_5554;
    exp_data[2] = 32'h5557_5557;
    exp_data[3] = 32'h5556_5556;
    exp_addr[0] = 27'd0;
    exp_addr[1] = 27'd2;
    exp_addr[2] = 27'd4;
    exp_addr[3] = 27'd6;
    for (int i = 0; i < 8; i++) begin
      corrupt[i] = '0;
    end
    n_checks  = 0;
    n_fail    = 0;
    model_en  = 1'b1;
    rst       = 1'b1;
    start     = 1'b0;
    init_done = 1'b0;
    busy      = 1'b0;
    ack_spur  = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check_reset_vals("rst");

    // Start before controller init is dropped
    pulse_start();
    tick();
    check_val("start_no_init_state", 64'(state), 64'd0);
    check_val("start_no_init_adv",   64'(adv_n), 64'd1);

    // Spurious ack in IDLE
    ack_spur = 1'b1;
    tick();
    ack_spur = 1'b0;
    tick();
    check_val("spur_idle_state", 64'(state), 64'd0);

    // Full pass run, with a spurious ack while held in WR_REQ
    init_done = 1'b1;
    busy      = 1'b1;
    base      = n_req;
    pulse_start();
    check_val("wrreq_state", 64'(state),   64'd1);
    check_val("wrreq_rwn",   64'(rwn),     64'd0);
    check_val("wrreq_wdata", 64'(wr_data), 64'h5555_5555);
    ack_spur = 1'b1;
    tick();
    ack_spur = 1'b0;
    check_val("spur_wrreq_state", 64'(state), 64'd1);
    check_val("spur_wrreq_addr",  64'(addr),  64'd0);
    busy = 1'b0;
    wait_state(3'd5, 200, "pass_reach_done");
    check_val("pass_done",    64'(done),        64'd1);
    check_val("pass_pass",    64'(pass),        64'd1);
    check_val("pass_errcnt",  64'(err_count),   64'd0);
    check_val("pass_tmo",     64'(tmo),         64'd0);
    check_val("pass_nreq",    64'(n_req - base), 64'd8);
    check_log(base, "pass");

    // Read corruption on words 2 and 3
    corrupt[2] = 32'h0000_0001;
    corrupt[3] = 32'h8000_0000;
    base = n_req;
    pulse_start();
    check_val("restart_done_clr", 64'(done), 64'd0);
    wait_state(3'd5, 200, "err_reach_done");
    check_val("err_done",    64'(done),      64'd1);
    check_val("err_pass",    64'(pass),      64'd0);
    check_val("err_errcnt",  64'(err_count), 64'd2);
    check_val("err_erraddr", 64'(err_addr),  64'd4);
    check_val("err_errdata", 64'(err_data),  64'h5557_5556);
    check_val("err_nreq",    64'(n_req - base), 64'd8);
    corrupt[2] = '0;
    corrupt[3] = '0;

    // Busy held for 50 cycles at the second write
    base = n_req;
    pulse_start();
    check_val("restart_errcnt_clr", 64'(err_count), 64'd0);
    for (int n = 0; n < 20 && (n_req - base) < 1; n++) tick();
    check_val("busy_first_req", 64'(n_req - base), 64'd1);
    busy       = 1'b1;
    bad_strobe = 0;
    bad_hold   = 0;
    for (int n = 0; n < 50; n++) begin
      tick();
      if (adv_n !== 1'b1) bad_strobe++;
      if (state == 3'd1 && (addr !== 27'd2 || wr_data !== 32'h5554_5554)) bad_hold++;
    end
    check_val("busy_no_strobe", 64'(bad_strobe), 64'd0);
    check_val("busy_hold",      64'(bad_hold),   64'd0);
    check_val("busy_state",     64'(state),      64'd1);
    check_val("busy_nreq",      64'(n_req - base), 64'd1);
    busy = 1'b0;
    #1;
    check_val("busy_drop_strobe", 64'(adv_n),   64'd0);
    check_val("busy_drop_addr",   64'(addr),    64'd2);
    check_val("busy_drop_data",   64'(wr_data), 64'h5554_5554);
    wait_state(3'd5, 200, "busy_reach_done");
    check_val("busy_pass", 64'(pass), 64'd1);
    check_log(base, "busy");

    // Controller never acks
    model_en = 1'b0;
    base     = n_req;
    pulse_start();
    repeat (16) tick();
    check_val("tmo_still_wait", 64'(state), 64'd2);
    tick();
    check_val("tmo_state", 64'(state), 64'd6);
    check_val("tmo_flag",  64'(tmo),   64'd1);
    check_val("tmo_done",  64'(done),  64'd1);
    check_val("tmo_pass",  64'(pass),  64'd0);
    repeat (20) tick();
    check_val("tmo_nreq",  64'(n_req - base), 64'd1);
    check_val("tmo_hold",  64'(state), 64'd6);
    check_val("tmo_adv_n", 64'(adv_n), 64'd1);

    // Reset during RD_WAIT, then a clean run
    model_en = 1'b1;
    pulse_start();
    wait_state(3'd4, 200, "reach_rd_wait");
    rst = 1'b1;
    tick();
    check_reset_vals("midrst");
    rst = 1'b0;
    repeat (5) tick();
    check_val("midrst_idle", 64'(state), 64'd0);
    base = n_req;
    pulse_start();
    wait_state(3'd5, 200, "rerun_reach_done");
    check_val("rerun_pass",   64'(pass),      64'd1);
    check_val("rerun_errcnt", 64'(err_count), 64'd0);
    check_val("rerun_nreq",   64'(n_req - base), 64'd8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
